uart_rx_framer: RTL and testbench

//  Serial-to-parallel UART receiver (8N1, LSB first) feeding the loopback/TX path.

---
 rtl/uart_rx_framer.sv | 156 +++++++++++++++
 tb/tb_uart_rx_framer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_framer.sv
// 8N1 UART receiver: synchronises rx, validates the start bit, samples each bit at its
// centre and hands bytes over a valid/ready handshake with framing-error and overrun pulses.
module uart_rx_framer #(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BAUD_RATE = 9600
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun
);

  localparam int BIT_CLKS  = CLK_FREQ / BAUD_RATE;
  localparam int HALF_CLKS = BIT_CLKS / 2;
  localparam int CW        = (BIT_CLKS > 2) ? $clog2(BIT_CLKS) : 1;

  localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CLKS - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_CLKS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t          state, state_d;
  logic [CW-1:0]   cnt, cnt_d;
  logic [2:0]      idx, idx_d;
  logic [7:0]      shift, shift_d;
  logic            deliver_q, deliver_d;
  logic            frame_err_d;
  logic            rx_meta, rx_s;

  // Line idles high, so the synchroniser resets to 1 to avoid a false start edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments let both stages sample the pre-edge values,
      // which is what makes this a two-flop chain rather than a single wire.
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // NOTE: the shift register is small and control-adjacent, so it is reset along with
  // the rest of the state; a large data memory would normally be left unreset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      idx       <= '0;
      shift     <= '0;
      deliver_q <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      idx       <= idx_d;
      shift     <= shift_d;
      deliver_q <= deliver_d;
      frame_err <= frame_err_d;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    state_d     = state;
    cnt_d       = cnt;
    idx_d       = idx;
    shift_d     = shift;
    deliver_d   = 1'b0;
    frame_err_d = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (!rx_s) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end

      S_START: begin
        if (cnt == HALF_LAST) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rx_s ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end

      S_DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_d        = '0;
          shift_d[idx] = rx_s;
          if (idx == 3'd7) state_d = S_STOP;
          else             idx_d   = idx + 3'd1;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end

      S_STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            deliver_d = 1'b1;
            state_d   = S_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_BREAK;
          end
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end

      // A line held low stays here so it never yields further bytes or errors.
      S_BREAK: begin
        if (rx_s) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Output holding register: a byte completing while the last one is unaccepted is dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_data  <= '0;
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (deliver_q) begin
        if (!rx_valid || rx_ready) begin
          rx_data  <= shift;
          rx_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_framer.sv
// Bench for uart_rx_framer: drives serial frames at a scaled baud rate and checks the
// DUT against a queue-based model of which bytes, framing errors and overruns must appear.
module tb_uart_rx_framer;

  localparam int CLK_FREQ  = 1_600_000;
  localparam int BAUD_RATE = 100_000;
  localparam int B         = CLK_FREQ / BAUD_RATE;

  logic       clk      = 1'b0;
  logic       reset    = 1'b1;
  logic       rx       = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;

  uart_rx_framer #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD_RATE(BAUD_RATE)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rx       (rx),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .frame_err(frame_err),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;

  logic [7:0] exp_q[$];
  int         exp_ferr = 0;
  int         exp_ovr  = 0;
  int         seen_ferr = 0;
  int         seen_ovr  = 0;
  int         rise_count = 0;
  int         rise_cyc   = 0;
  int         acc_count  = 0;
  int         fall_cyc   = 0;
  logic [7:0] last_acc   = '0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp,
                       input int tol = 0);
    int  diff;
    bit  ok;
    vectors++;
    if (tol == 0) begin
      ok = (act === exp);
    end else begin
      diff = int'(act) - int'(exp);
      ok   = !$isunknown(act) && (diff <= tol) && (diff >= -tol);
    end
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (tol %0d) at cycle %0d", name, act, exp, tol, cyc);
    end
  endtask

  // Serial frame as sent on the wire, LSB first: start 0, eight data bits, stop bit.
  function automatic logic [9:0] frame_word(input logic [7:0] d, input logic stop);
    return {stop, d, 1'b0};
  endfunction

  // Outcome of a frame judged at the centre of its stop bit.
  task automatic model_frame(input logic [7:0] d, input logic stop);
    if (!stop)                                  exp_ferr++;
    else if (exp_q.size() != 0 && !rx_ready)    exp_ovr++;
    else                                        exp_q.push_back(d);
  endtask

  // Called at a falling clock edge; returns at the falling edge ending the stop bit.
  task automatic send_frame(input logic [7:0] d, input logic stop);
    logic [9:0] w;
    w = frame_word(d, stop);
    fall_cyc = cyc;
    for (int k = 0; k < 9; k++) begin
      rx = w[k];
      repeat (B) @(negedge clk);
    end
    rx = w[9];
    repeat (B / 2) @(negedge clk);
    model_frame(d, stop);
    repeat (B - B / 2) @(negedge clk);
  endtask

  // Compare process: runs just after each falling edge, when outputs and inputs are settled.
  logic       prev_hold  = 1'b0;
  logic       prev_valid = 1'b0;
  logic       prev_ferr  = 1'b0;
  logic       prev_ovr   = 1'b0;
  logic [7:0] prev_data  = '0;

  always begin
    @(negedge clk);
    #1;
    if (!reset) begin
      check("reset_outputs", {21'd0, rx_data, rx_valid, frame_err, overrun}, 32'd0);
      prev_hold  = 1'b0;
      prev_valid = 1'b0;
      prev_ferr  = 1'b0;
      prev_ovr   = 1'b0;
    end else begin
      check("flags_exclusive", {31'd0, frame_err & overrun}, 32'd0);
      if (frame_err) begin
        check("frame_err_width", {31'd0, prev_ferr}, 32'd0);
        seen_ferr++;
      end
      if (overrun) begin
        check("overrun_width", {31'd0, prev_ovr}, 32'd0);
        seen_ovr++;
      end
      if (prev_hold) begin
        check("valid_held", {31'd0, rx_valid}, 32'd1);
        check("data_stable", {24'd0, rx_data}, {24'd0, prev_data});
      end
      if (rx_valid && !prev_valid) begin
        rise_cyc = cyc;
        rise_count++;
      end
      if (rx_valid && rx_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_byte", {24'd0, rx_data}, 32'hFFFF_FFFF);
        end else begin
          check("rx_data", {24'd0, rx_data}, {24'd0, exp_q.pop_front()});
        end
        last_acc = rx_data;
        acc_count++;
      end
      prev_hold  = rx_valid && !rx_ready;
      prev_valid = rx_valid;
      prev_ferr  = frame_err;
      prev_ovr   = overrun;
      prev_data  = rx_data;
    end
  end

  initial begin
    #300_000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int rc;
    int ac;
    int lat2;

    #1 reset = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);

    // Pin the frame model against hand-assembled wire patterns.
    check("pin_frame_55", {22'd0, frame_word(8'h55, 1'b1)}, 32'h2AA);
    check("pin_frame_a3", {22'd0, frame_word(8'hA3, 1'b0)}, 32'h146);

    // 1: single 0x55 with ready high; latency 9.5 bit periods + 3 clocks, in half-clock units.
    rx_ready = 1'b1;
    rc = rise_count;
    send_frame(8'h55, 1'b1);
    repeat (3 * B) @(negedge clk);
    check("s1_one_valid", rise_count - rc, 1);
    lat2 = 2 * (rise_cyc - fall_cyc) - 1;
    check("s1_latency_x2", lat2, 19 * B + 6, 2);
    check("s1_data", {24'd0, last_acc}, 32'h55);
    check("s1_no_flags", seen_ferr + seen_ovr, 0);

    // 2: two frames with nobody accepting -> first held, second overruns.
    rx_ready = 1'b0;
    send_frame(8'h55, 1'b1);
    send_frame(8'h00, 1'b1);
    repeat (2 * B) @(negedge clk);
    check("s2_overrun", seen_ovr, 1);
    check("s2_hold_valid", {31'd0, rx_valid}, 32'd1);
    check("s2_hold_data", {24'd0, rx_data}, 32'h55);
    rx_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("s2_valid_drop", {31'd0, rx_valid}, 32'd0);
    check("s2_accepted", {24'd0, last_acc}, 32'h55);

    // 3: short low glitch is rejected at the start-bit centre.
    rc = rise_count;
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (2 * B) @(negedge clk);
    check("s3_no_valid", rise_count - rc, 0);
    check("s3_no_ferr", seen_ferr, 0);

    // 4: bad stop bit with the line held low, then a good frame.
    rc = rise_count;
    send_frame(8'hA3, 1'b0);
    repeat (2 * B) @(negedge clk);
    rx = 1'b1;
    repeat (2 * B) @(negedge clk);
    check("s4_ferr_once", seen_ferr, 1);
    check("s4_no_valid", rise_count - rc, 0);
    send_frame(8'h3C, 1'b1);
    repeat (2 * B) @(negedge clk);
    check("s4_data", {24'd0, last_acc}, 32'h3C);

    // 5: reset in the middle of 0xFF's data bits abandons it.
    rx = 1'b0;
    repeat (B) @(negedge clk);
    rx = 1'b1;
    repeat (3 * B) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    check("s5_in_reset", {21'd0, rx_data, rx_valid, frame_err, overrun}, 32'd0);
    reset = 1'b1;
    repeat (2 * B) @(negedge clk);
    rc = rise_count;
    send_frame(8'h12, 1'b1);
    repeat (2 * B) @(negedge clk);
    check("s5_one_valid", rise_count - rc, 1);
    check("s5_data", {24'd0, last_acc}, 32'h12);

    // 6: ten random bytes back-to-back; the compare process checks order and value.
    ac = acc_count;
    for (int i = 0; i < 10; i++) begin
      send_frame(8'($urandom_range(0, 255)), 1'b1);
    end
    repeat (2 * B) @(negedge clk);
    check("s6_count", acc_count - ac, 10);

    check("queue_empty", exp_q.size(), 0);
    check("ferr_total", seen_ferr, exp_ferr);
    check("ovr_total", seen_ovr, exp_ovr);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
